// File: rtl/layer_feed_buffer.sv
// Collects NUM_IN activation words into a shadow frame and publishes them to
// the node-facing lane registers in one cycle; out_valid trails each publish.
module layer_feed_buffer #(
    parameter int unsigned NUM_IN       = 15,
    parameter int unsigned NODE_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] A0x,
    output logic [31:0] A1x,
    output logic [31:0] A2x,
    output logic [31:0] A3x,
    output logic [31:0] A4x,
    output logic [31:0] A5x,
    output logic [31:0] A6x,
    output logic [31:0] A7x,
    output logic [31:0] A8x,
    output logic [31:0] A9x,
    output logic [31:0] A10x,
    output logic [31:0] A11x,
    output logic [31:0] A12x,
    output logic [31:0] A13x,
    output logic [31:0] A14x,
    output logic        frame_valid,
    output logic        out_valid,
    output logic [15:0] frame_count
);

    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        FILL,
        PUBLISH
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             shadow_q [NUM_IN];
    logic [31:0]             lane_q   [NUM_IN];
    logic                    frame_valid_q;
    logic [NODE_LATENCY-1:0] delay_q;
    logic [15:0]             frame_count_q;
    logic                    xfer;
    logic                    publish;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // in_ready is gated by reset so it drops the moment reset asserts.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_ready = 1'b0;
        xfer     = 1'b0;
        publish  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = reset & ~flush;
                xfer     = in_valid & in_ready;
                if (flush) begin
                    idx_d = '0;
                end else if (xfer) begin
                    if (idx_q == IDX_W'(NUM_IN - 1)) begin
                        idx_d   = '0;
                        state_d = PUBLISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PUBLISH: begin
                publish = 1'b1;
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                shadow_q[i] <= '0;
                lane_q[i]   <= '0;
            end
        end else begin
            if (xfer) begin
                shadow_q[idx_q] <= in_data;
            end
            if (publish) begin
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    lane_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            delay_q       <= '0;
        end else begin
            frame_valid_q <= publish;
            if (publish) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            delay_q[0] <= frame_valid_q;
            for (int unsigned i = 1; i < NODE_LATENCY; i++) begin
                delay_q[i] <= delay_q[i-1];
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign out_valid   = delay_q[NODE_LATENCY-1];
    assign frame_count = frame_count_q;

    assign A0x  = lane_q[0];
    assign A1x  = lane_q[1];
    assign A2x  = lane_q[2];
    assign A3x  = lane_q[3];
    assign A4x  = lane_q[4];
    assign A5x  = lane_q[5];
    assign A6x  = lane_q[6];
    assign A7x  = lane_q[7];
    assign A8x  = lane_q[8];
    assign A9x  = lane_q[9];
    assign A10x = lane_q[10];
    assign A11x = lane_q[11];
    assign A12x = lane_q[12];
    assign A13x = lane_q[13];
    assign A14x = lane_q[14];

endmodule

// File: doc/layer_feed_buffer.md
LAYER_FEED_BUFFER -- requirements
Module: layer_feed_buffer

Interface
REQ-001 Parameter NUM_IN, 15, number of activation lanes presented to one downstream node.
REQ-002 Parameter NODE_LATENCY, 3, cycles from activation update to a valid node output (input register, sum register, output register).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of the partially filled frame.
REQ-006 in_data  input  32  activation word; previous-layer output or sample, passed unmodified.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 A0x..A14x  output  32 each  registered activations driving the node; lane k holds the k-th accepted word of the frame.
REQ-010 frame_valid  output  1  one-cycle pulse in the cycle A0x..A14x first carry a new frame.
REQ-011 out_valid  output  1  one-cycle pulse exactly NODE_LATENCY cycles after each frame_valid pulse.
REQ-012 frame_count  output  16  number of frames published, modulo 2^16.

Function
REQ-013 Transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; no other beat is consumed.
REQ-014 FSM states SHALL be FILL and PUBLISH; reset state FILL.
REQ-015 In FILL, in_ready SHALL equal NOT flush; each transfer writes in_data into shadow lane idx, then idx increments.
REQ-016 Transfer with idx=NUM_IN-1 SHALL set idx to 0 and move FILL->PUBLISH.
REQ-017 In PUBLISH (exactly one cycle), in_ready=0, all shadow lanes SHALL copy to A0x..A14x simultaneously, frame_valid=1 in the following cycle, frame_count increments, state returns to FILL.
REQ-018 A0x..A14x SHALL hold their value between publishes; partial frames never reach the outputs.
REQ-019 Sustained throughput: one frame per NUM_IN+1 cycles with in_valid held high.
REQ-020 out_valid SHALL be generated by an NODE_LATENCY-deep delay line of frame_valid, so overlapping frames each produce their own pulse.
REQ-021 frame_count SHALL wrap 0xFFFF->0x0000 without other side effect.
REQ-022 flush=1 in FILL SHALL set idx to 0, accept no beat, and leave outputs, frame_count and delay line unchanged.
REQ-023 flush=1 in PUBLISH SHALL not abort the publish; idx remains 0.
REQ-024 flush and in_valid in the same cycle: flush wins, beat not consumed.
REQ-025 No arithmetic or sign change on data; lane width 32 bits end to end.

Reset
REQ-026 reset low SHALL immediately force A0x..A14x=0, frame_valid=0, out_valid=0, frame_count=0, in_ready=0, idx=0, delay line cleared, state FILL.
REQ-027 After reset deasserts, in_ready SHALL be 1 on the first cycle unless flush=1.
REQ-028 reset asserted mid-fill or mid-PUBLISH SHALL discard the frame; no frame_valid or out_valid pulse follows for it.

Verification
REQ-029 Stream words 1..15 back-to-back -> A0x=1..A14x=15 together, frame_valid one pulse 1 cycle after 15th transfer, out_valid 3 cycles later, frame_count=1.
REQ-030 Stream 30 words continuously -> in_ready low exactly one cycle after word 15; second frame A0x=16..A14x=30; frame_count=2.
REQ-031 Send 7 words, flush, then words 100..114 -> outputs 100..114, first 7 words never visible, frame_count=1.
REQ-032 Assert reset low after 10 words -> all outputs 0 asynchronously; after release, 15 new words publish correctly with no stale out_valid.
REQ-033 Preload frame_count=0xFFFF via 65535 frames (or force) then publish one -> frame_count=0x0000, outputs correct.
REQ-034 Random in_valid gaps plus flush coinciding with in_valid -> scoreboard matches lane order; flush-cycle beat never consumed.
